uart_rx_core: RTL

Receive half of UART0 inside AISoc. Consumes the asynchronous `rx0` pad line, recovers 8N1 frames with 16x oversampling, and buffers received bytes in a small FIFO. Bytes are presented to the UART0 bus-register block through a valid/ready stream. Framing errors and overflow are reported as status.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_sync_fifo.sv | 51 +++++
 rtl/uart_rx_core.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART0 definitions: receive FSM states and the oversampling/frame constants
// used by both the receive and transmit cores.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_IDLE
   } rx_state_t;

   localparam int OVERSAMPLE  = 16;
   localparam int MID_SAMPLE  = 7;
   localparam int LAST_SAMPLE = 15;
   localparam int DATA_BITS   = 8;

   localparam int OS_W  = $clog2(OVERSAMPLE);
   localparam int BIT_W = $clog2(DATA_BITS);

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with extra-bit pointers; the head word is shown combinationally
// and forced to zero while empty so the output is clean after reset.
module uart_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr_reg;
   logic [AW:0]      rd_ptr_reg;
   logic             push_ok;
   logic             pop_ok;

   assign level    = wr_ptr_reg - rd_ptr_reg;
   assign empty    = (level == '0);
   // Level never exceeds DEPTH, so its top bit alone marks full.
   assign full     = level[AW];
   assign pop_ok   = pop && !empty;
   assign push_ok  = push && (!full || pop_ok);
   assign pop_data = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr_reg[AW-1:0]] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
         if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
   end

endmodule

// File: rtl/uart_rx_core.sv
// UART0 receiver: 8N1 frame recovery with 16x oversampling into a byte FIFO,
// with framing-error pulse and sticky overflow status.
module uart_rx_core #(
   parameter int BAUD_DIV   = 54,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          resetn,
   input  logic                          rx,
   output logic [7:0]                    m_data,
   output logic                          m_valid,
   input  logic                          m_ready,
   output logic                          frame_err,
   output logic                          overflow,
   input  logic                          ovf_clr,
   output logic                          rx_busy,
   output logic [$clog2(FIFO_DEPTH):0]   level
);

   import uart_pkg::*;

   localparam int TCW = $clog2(BAUD_DIV);
   localparam logic [TCW-1:0] TICK_LAST = TCW'(BAUD_DIV - 1);
   localparam logic [OS_W-1:0] OS_MID   = OS_W'(MID_SAMPLE);
   localparam logic [OS_W-1:0] OS_LAST  = OS_W'(LAST_SAMPLE);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

   logic [1:0]           sync_reg;
   logic                 rxs;
   logic [TCW-1:0]       tick_cnt_reg;
   logic                 tick;
   rx_state_t            state_reg, state_next;
   logic [OS_W-1:0]      os_cnt_reg, os_cnt_next;
   logic [BIT_W-1:0]     bit_cnt_reg, bit_cnt_next;
   logic [DATA_BITS-1:0] rx_data_reg, rx_data_next;
   logic                 byte_push;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic                 pop;
   logic                 ovf_set;
   logic                 overflow_reg;

   // Two-flop synchronizer; idles high so reset never looks like a start bit.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) sync_reg <= 2'b11;
      else         sync_reg <= {sync_reg[0], rx};
   end
   assign rxs = sync_reg[1];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)   tick_cnt_reg <= '0;
      else if (tick) tick_cnt_reg <= '0;
      else           tick_cnt_reg <= tick_cnt_reg + TCW'(1);
   end
   assign tick = (tick_cnt_reg == TICK_LAST);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_reg   <= IDLE;
         os_cnt_reg  <= '0;
         bit_cnt_reg <= '0;
         rx_data_reg <= '0;
      end else begin
         state_reg   <= state_next;
         os_cnt_reg  <= os_cnt_next;
         bit_cnt_reg <= bit_cnt_next;
         rx_data_reg <= rx_data_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      os_cnt_next  = os_cnt_reg;
      bit_cnt_next = bit_cnt_reg;
      rx_data_next = rx_data_reg;
      if (tick) begin
         case (state_reg)
            IDLE: begin
               if (!rxs) begin
                  state_next  = START;
                  os_cnt_next = '0;
               end
            end
            START: begin
               if (os_cnt_reg == OS_MID) begin
                  os_cnt_next  = '0;
                  bit_cnt_next = '0;
                  state_next   = rxs ? IDLE : DATA;
               end else begin
                  os_cnt_next = os_cnt_reg + OS_W'(1);
               end
            end
            DATA: begin
               os_cnt_next = os_cnt_reg + OS_W'(1);
               if (os_cnt_reg == OS_LAST) begin
                  rx_data_next = {rxs, rx_data_reg[DATA_BITS-1:1]};
                  bit_cnt_next = bit_cnt_reg + BIT_W'(1);
                  if (bit_cnt_reg == BIT_LAST) state_next = STOP;
               end
            end
            STOP: begin
               os_cnt_next = os_cnt_reg + OS_W'(1);
               if (os_cnt_reg == OS_LAST) state_next = rxs ? IDLE : WAIT_IDLE;
            end
            WAIT_IDLE: begin
               if (rxs) state_next = IDLE;
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_comb begin
      rx_busy   = (state_reg != IDLE);
      byte_push = 1'b0;
      frame_err = 1'b0;
      if (tick && state_reg == STOP && os_cnt_reg == OS_LAST) begin
         byte_push = rxs;
         frame_err = !rxs;
      end
   end

   assign pop     = m_ready && !fifo_empty;
   assign ovf_set = byte_push && fifo_full && !pop;
   assign m_valid = !fifo_empty;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)      overflow_reg <= 1'b0;
      else if (ovf_set) overflow_reg <= 1'b1;
      else if (ovf_clr) overflow_reg <= 1'b0;
   end
   assign overflow = overflow_reg;

   uart_sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .resetn    (resetn),
      .push      (byte_push),
      .push_data (rx_data_reg),
      .pop       (pop),
      .pop_data  (m_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (level)
   );

endmodule
